hit_judge: RTL
==============

# hit_judge

Scoring stage directly downstream of the note scroller. It samples the scroller's judge-lane bits (`note_R_judge`, `note_B_judge`) and pixel `offset`, debounces the red and blue player buttons, and grades each note as perfect, good or miss. On a hit it returns a one-cycle `delete` pulse to the scroller so the note is cleared. It also maintains score, combo and max combo for the 7-segment and LED display logic.

## Interface
Parameters:
- `DB_CYCLES`, default 17'd99999: a button must be stable for this many cycles before its debounced level changes.
- `PERFECT_PTS`, default 4'd3: points added for a perfect hit.
- `GOOD_PTS`, default 4'd1: points added for a good hit.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `song` in 2: song select. 0 means none.
- `red_button` in 1: raw asynchronous button.
- `blue_button` in 1: raw asynchronous button.
- `yellow_button` in 1: restart/acknowledge, already debounced level.
- `note_R_judge` in 1: red note occupies the judge lane.
- `note_B_judge` in 1: blue note occupies the judge lane.
- `offset` in 3: scroller sub-step, 0..6.
- `finish` in 1: song end indication.
- `delete` out 1: one-cycle pulse that clears the judge-lane note.
- `score` out 14: saturates at 9999.
- `combo` out 8: saturates at 255.
- `max_combo` out 8: highest combo reached.
- `last_grade` out 2: 0 none, 1 miss, 2 good, 3 perfect.
- `playing` out 1: high while in PLAY.

## Operation
- **Synchronizer:** each of red/blue passes through a 2-flop synchronizer giving `s`.
- **Debouncer:** per button, a counter clears whenever `s` equals the debounced level `db`, otherwise increments. When the counter reaches `DB_CYCLES` while `s != db`, `db` takes `s` and the counter clears.
  - `press_X` is a 1-cycle pulse on the rising edge of `db_X`.
  - Releases generate nothing.
- **State machine:** IDLE, PLAY, DONE.
  - IDLE→PLAY when `song != 0`. On entry, `score`, `combo`, `max_combo` and `last_grade` clear to 0 and the per-lane resolved flags clear.
  - PLAY→DONE when `finish == 1`.
  - DONE→IDLE when `yellow_button == 1`.
  - Counters hold in IDLE and DONE. Button presses and judge edges are ignored outside PLAY.
- **Per-lane resolved flag `res_X`:**
  - Set on a hit in that lane.
  - Cleared in any cycle where `note_X_judge == 0`.
- **Hit, in PLAY:** `press_X && note_X_judge && !res_X`.
  - Grade is perfect if `offset` is 2..4, good otherwise.
  - Add the grade's points to `score`, plus 1 bonus point if `combo >= 10` before the increment.
  - `combo` +1, `max_combo` updates to `max(max_combo, new combo)`, `last_grade` set, `delete` pulses.
- **Wrong press, in PLAY:** `press_X` with `note_X_judge == 0`.
  - `combo` → 0, `last_grade` = miss, no score change.
  - A press on an already-resolved note is ignored.
- **Miss, in PLAY:** falling edge of `note_X_judge`, i.e. registered previous value 1 and current 0, while `res_X == 0`.
  - `combo` → 0, `last_grade` = miss.
- **Simultaneous events:**
  - If any hit occurs in a cycle, wrong presses and misses in that same cycle are ignored.
  - Otherwise a wrong press and a miss in the same cycle together produce a single `combo` reset.
- **Widths and saturation:**
  - `score` arithmetic is done in 15 bits and clamped to 9999.
  - `combo` holds at 255 once reached; `max_combo` follows it.

## Timing
- All outputs are registered. Reset value of every output is 0; state resets to IDLE; synchronizers, debouncers and flags reset to 0.
- **Button latency:** raw red rising at edge k gives `s` at k+2, `db` at k+2+DB_CYCLES+1, and `press` in the following cycle.
- **Grading latency:** `press` in cycle n gives `delete`, `score`, `combo` and `last_grade` updated at edge n+1.
- **Delete pulse:** exactly 1 cycle, never two in consecutive cycles for the same note, because `res_X` is set at the same edge.
- **Judge bit after delete:** the judge bit falls a few cycles after `delete`. That fall is not a miss, since `res_X == 1`.
- **Reset mid-song:** the next edge returns everything to reset values, even if a `delete` pulse was in progress.

## Test plan
All scenarios use DB_CYCLES=4.
1. **Perfect hit:** `song=1`, hold `note_R_judge=1` with `offset=3`, press red for 10 cycles → one `delete` pulse, `score=3`, `combo=1`, `last_grade=3`. Then drop `note_R_judge` → no miss, `combo` stays 1.
2. **Good hit:** same as scenario 1 with `offset=6` → `score=1`, `last_grade=2`.
3. **Miss and wrong press:** raise then drop `note_B_judge` with no press → `combo=0`, `last_grade=1`. A red press with no red judge bit → `combo=0`, `score` unchanged, `delete` stays 0.
4. **Combo bonus and saturation:**
   - 11 consecutive perfect hits → `score=3*11+1=34`, `combo=11`, `max_combo=11`.
   - Force 256 hits → `combo` and `max_combo` at 255.
   - Preset `score` near its cap → `score` at 9999.
5. **Debounce:** red glitch high for 3 cycles → no `press`. Stable high → `press` at the computed edge.
6. **FSM and reset:**
   - `finish=1` → `playing=0`; presses ignored; counters hold.
   - `yellow_button` → IDLE; a new `song` clears `score`.
   - `rst` during a hit → all outputs 0 at the next edge.

Source files
------------

// File: rtl/hit_judge.sv
// Rhythm-game judge stage: debounces the red/blue buttons, grades judge-lane notes
// against the scroller offset, and keeps score, combo and max combo.
module hit_judge #(
    parameter logic [16:0] DB_CYCLES   = 17'd99999,
    parameter logic [3:0]  PERFECT_PTS = 4'd3,
    parameter logic [3:0]  GOOD_PTS    = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  song,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        yellow_button,
    input  logic        note_R_judge,
    input  logic        note_B_judge,
    input  logic [2:0]  offset,
    input  logic        finish,
    output logic        delete,
    output logic [13:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic [1:0]  last_grade,
    output logic        playing
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    localparam logic [14:0] SCORE_MAX = 15'd9999;
    localparam logic [1:0]  G_MISS    = 2'd1;
    localparam logic [1:0]  G_GOOD    = 2'd2;
    localparam logic [1:0]  G_PERFECT = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  sync1_q, sync2_q;       // index 0 = red lane, 1 = blue lane
    logic [1:0]  db_q, db_d, db_prev_q;
    logic [16:0] cnt_q [2];
    logic [16:0] cnt_d [2];
    logic [1:0]  judge_prev_q, res_q, res_d;
    logic [13:0] score_q, score_d;
    logic [7:0]  combo_q, combo_d, max_q, max_d;
    logic [1:0]  grade_q, grade_d;
    logic        delete_q, delete_d, playing_q, playing_d;

    logic [1:0]  judge, press, hit, wrong, miss;
    logic [14:0] sum;
    logic [3:0]  pts;

    assign judge = {note_B_judge, note_R_judge};
    assign press = db_q & ~db_prev_q;

    // Debounced level only moves after the synchronized input disagrees for DB_CYCLES.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = 17'd0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_CYCLES) db_d[i] = sync2_q[i];
                else                       cnt_d[i] = cnt_q[i] + 17'd1;
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        combo_d  = combo_q;
        max_d    = max_q;
        grade_d  = grade_q;
        delete_d = 1'b0;
        sum      = 15'd0;
        pts      = 4'd0;
        res_d    = res_q & judge;
        hit      = press & judge & ~res_q;
        wrong    = press & ~judge;
        miss     = judge_prev_q & ~judge & ~res_q;

        unique case (state_q)
            S_IDLE: begin
                if (song != 2'd0) begin
                    state_d = S_PLAY;
                    score_d = 14'd0;
                    combo_d = 8'd0;
                    max_d   = 8'd0;
                    grade_d = 2'd0;
                    res_d   = 2'b00;
                end
            end
            S_PLAY: begin
                if (finish) state_d = S_DONE;
                if (|hit) begin
                    delete_d = 1'b1;
                    // Lanes are graded in order, so a same-cycle double hit counts twice.
                    for (int i = 0; i < 2; i++) begin
                        if (hit[i]) begin
                            pts     = (offset >= 3'd2 && offset <= 3'd4) ? PERFECT_PTS : GOOD_PTS;
                            grade_d = (offset >= 3'd2 && offset <= 3'd4) ? G_PERFECT : G_GOOD;
                            sum     = 15'(score_d) + 15'(pts) + ((combo_d >= 8'd10) ? 15'd1 : 15'd0);
                            score_d = (sum > SCORE_MAX) ? SCORE_MAX[13:0] : sum[13:0];
                            if (combo_d != 8'd255) combo_d = combo_d + 8'd1;
                            if (combo_d > max_d) max_d = combo_d;
                            res_d[i] = 1'b1;
                        end
                    end
                end else if ((|wrong) || (|miss)) begin
                    combo_d = 8'd0;
                    grade_d = G_MISS;
                end
            end
            S_DONE: begin
                if (yellow_button) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        playing_d = (state_d == S_PLAY);
    end

    // NOTE: state uses non-blocking assignments so all flops update from the same old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            db_q         <= 2'b00;
            db_prev_q    <= 2'b00;
            cnt_q[0]     <= 17'd0;
            cnt_q[1]     <= 17'd0;
            judge_prev_q <= 2'b00;
            res_q        <= 2'b00;
            score_q      <= 14'd0;
            combo_q      <= 8'd0;
            max_q        <= 8'd0;
            grade_q      <= 2'd0;
            delete_q     <= 1'b0;
            playing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= {blue_button, red_button};
            sync2_q      <= sync1_q;
            db_q         <= db_d;
            db_prev_q    <= db_q;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            judge_prev_q <= judge;
            res_q        <= res_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            max_q        <= max_d;
            grade_q      <= grade_d;
            delete_q     <= delete_d;
            playing_q    <= playing_d;
        end
    end

    assign delete     = delete_q;
    assign score      = score_q;
    assign combo      = combo_q;
    assign max_combo  = max_q;
    assign last_grade = grade_q;
    assign playing    = playing_q;

endmodule
